// File: rtl/veririsc_pkg.sv
// rtl/veririsc_pkg.sv - VeriRISC opcode/state encodings shared by controller, ALU and top
package veririsc_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  // Opcodes that read an operand from memory and write the accumulator
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/veririsc_controller.sv
// rtl/veririsc_controller.sv - 8-phase VeriRISC instruction sequencer with sticky HALTED state
module veririsc_controller
  import veririsc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ac,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       halt
);

  state_t  state;
  state_t  state_next;
  opcode_t op;
  logic    aluop;

  assign op    = opcode_t'(opcode);
  assign aluop = is_aluop(op);

  // State register; reset always returns to the start of a fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INST_ADDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode; opcode is only looked at from OP_ADDR onward
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    load_ir    = 1'b0;
    load_ac    = 1'b0;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    halt       = 1'b0;

    case (state)
      INST_ADDR: begin
        state_next = INST_FETCH;
      end
      INST_FETCH: begin
        mem_rd     = 1'b1;
        state_next = INST_LOAD;
      end
      INST_LOAD: begin
        mem_rd     = 1'b1;
        load_ir    = 1'b1;
        state_next = IDLE;
      end
      IDLE: begin
        mem_rd     = 1'b1;
        load_ir    = 1'b1;
        state_next = OP_ADDR;
      end
      OP_ADDR: begin
        if (op == HLT) begin
          halt       = 1'b1;
          state_next = HALTED;
        end else begin
          inc_pc     = 1'b1;
          state_next = OP_FETCH;
        end
      end
      OP_FETCH: begin
        mem_rd     = aluop;
        state_next = ALU_OP;
      end
      ALU_OP: begin
        mem_rd     = aluop;
        load_ac    = aluop;
        inc_pc     = (op == SKZ) && zero;
        load_pc    = (op == JMP);
        state_next = STORE;
      end
      STORE: begin
        mem_rd     = aluop;
        load_ac    = aluop;
        load_pc    = (op == JMP);
        mem_wr     = (op == STO);
        state_next = INST_ADDR;
      end
      HALTED: begin
        halt       = 1'b1;
        state_next = HALTED;
      end
      default: begin
        state_next = INST_ADDR;
      end
    endcase

    // Reset masks every strobe so no write or load can slip out mid-reset
    if (rst) begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      load_ir = 1'b0;
      load_ac = 1'b0;
      inc_pc  = 1'b0;
      load_pc = 1'b0;
      halt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_veririsc_controller.sv
// tb/tb_veririsc_controller.sv - table-driven bench for veririsc_controller
module tb_veririsc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_ir;
  logic       load_ac;
  logic       inc_pc;
  logic       load_pc;
  logic       halt;

  int checks = 0;
  int passed = 0;

  // outputs packed as {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_RD   = 7'b1000000;
  localparam logic [6:0] O_WR   = 7'b0100000;
  localparam logic [6:0] O_RDIR = 7'b1010000;
  localparam logic [6:0] O_RDAC = 7'b1001000;
  localparam logic [6:0] O_INC  = 7'b0000100;
  localparam logic [6:0] O_LDPC = 7'b0000010;
  localparam logic [6:0] O_HALT = 7'b0000001;

  typedef struct {
    string           name;
    logic [2:0]      op;
    logic            z;
    logic [0:7][6:0] exp;
  } vec_t;

  vec_t tbl[9];

  veririsc_controller dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .load_ir (load_ir),
    .load_ac (load_ac),
    .inc_pc  (inc_pc),
    .load_pc (load_pc),
    .halt    (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt};
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%b want=%b", name, got, exp);
  endtask

  // Entered at the start of cycle 1 (INST_ADDR); leaves at the start of the next cycle
  task automatic run_instr(input int idx, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      opcode = (c >= 4) ? tbl[idx].op : 3'bxxx;
      zero   = (c == 6) ? tbl[idx].z : ~tbl[idx].z;
      @(negedge clk);
      chk($sformatf("%s c%0d", tbl[idx].name, c + 1), tbl[idx].exp[c]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tbl[0] = '{"LDA", 3'd5, 1'b0, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_RD, O_RDAC, O_RDAC}};
    tbl[1] = '{"ADD", 3'd2, 1'b1, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_RD, O_RDAC, O_RDAC}};
    tbl[2] = '{"AND", 3'd3, 1'b0, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_RD, O_RDAC, O_RDAC}};
    tbl[3] = '{"XOR", 3'd4, 1'b1, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_RD, O_RDAC, O_RDAC}};
    tbl[4] = '{"STO", 3'd6, 1'b0, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_NONE, O_NONE, O_WR}};
    tbl[5] = '{"SKZ1", 3'd1, 1'b1, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_NONE, O_INC, O_NONE}};
    tbl[6] = '{"SKZ0", 3'd1, 1'b0, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_NONE, O_NONE, O_NONE}};
    tbl[7] = '{"JMP", 3'd7, 1'b0, {O_NONE, O_RD, O_RDIR, O_RDIR, O_INC, O_NONE, O_LDPC, O_LDPC}};
    tbl[8] = '{"HLT", 3'd0, 1'b0, {O_NONE, O_RD, O_RDIR, O_RDIR, O_HALT, O_HALT, O_HALT, O_HALT}};

    rst    = 1'b1;
    opcode = 3'bxxx;
    zero   = 1'b0;

    // reset held for two edges with an unknown opcode
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("reset c%0d", i), O_NONE);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // back-to-back instructions: each must take exactly 8 clocks
    for (int i = 0; i < 8; i++) run_instr(i, 8);

    // HLT then stay frozen
    run_instr(8, 8);
    for (int i = 0; i < 20; i++) begin
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("halted hold %0d", i), O_HALT);
      @(posedge clk);
      #1;
    end

    // reset out of HALTED, then a normal instruction
    rst = 1'b1;
    @(negedge clk);
    chk("reset in halted", O_NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(0, 8);

    // reset during STORE of a STO: no write, fetch restarts
    run_instr(4, 7);
    opcode = 3'd6;
    rst    = 1'b1;
    @(negedge clk);
    chk("mid store reset", O_NONE);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    opcode = 3'bxxx;
    @(negedge clk);
    chk("post reset inst_addr", O_NONE);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post reset inst_fetch", O_RD);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/veririsc_controller.md
# veririsc_controller

Instruction sequencer for the VeriRISC datapath. Steps through a fixed 8-phase fetch/execute cycle per instruction and decodes the 3-bit opcode, plus the accumulator zero flag, into the load enables and memory strobes. Sits directly upstream of the instruction and accumulator `register` instances (drives their `enable`), the program counter and the memory. Adds an absorbing HALTED state so a halted core stays frozen until reset.

## Interface
- No parameters; opcode and state encodings come from `veririsc_pkg`.
- `clk`  in  1  rising-edge clock, single domain.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  3  `instr[7:5]` from instruction register output; `opcode_t`.
- `zero`  in  1  accumulator == 0, from ALU/accumulator.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `load_ir`  out  1  instruction register `enable`.
- `load_ac`  out  1  accumulator register `enable`.
- `inc_pc`  out  1  program counter increment.
- `load_pc`  out  1  program counter parallel load.
- `halt`  out  1  core halted; sticky until `rst`.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD, AND, XOR or LDA.
- States, in order: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
- Each phase advances one state per clock; STORE wraps to INST_ADDR.
- Outputs per state (unlisted outputs = 0):
  - INST_ADDR: all 0.
  - INST_FETCH: mem_rd=1.
  - INST_LOAD: mem_rd=1, load_ir=1.
  - IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR with opcode≠HLT: inc_pc=1.
  - OP_ADDR with opcode=HLT: halt=1, inc_pc=0; next state HALTED.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(SKZ && zero), load_pc=JMP.
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, load_pc=JMP, mem_wr=STO.
  - HALTED: halt=1 only; holds state until `rst`.
- Outputs are combinational decode of the registered state plus `opcode`/`zero`. No output register.

## Timing
- Reset:
  - `rst` high at a rising edge → state=INST_ADDR after that edge.
  - While `rst` is high, all outputs are forced 0 combinationally, so mem_wr/load_* cannot pulse during reset.
- Reset mid-instruction (any state, including HALTED): takes effect at the next edge. The partial instruction is abandoned; no write completes.
- Latency:
  - Exactly 8 clocks per non-halting instruction.
  - First INST_ADDR begins the cycle after reset is released.
- IR enable timing: load_ir high for 2 cycles (INST_LOAD, IDLE). The IR captures at both edges; `opcode` is valid from OP_ADDR onward.
- `zero` is sampled only during ALU_OP. It must be stable in that cycle; SKZ skips via an extra inc_pc there.
- HLT:
  - halt rises in OP_ADDR and remains 1 in HALTED.
  - inc_pc is never asserted for HLT.
  - Total clocks from INST_ADDR to first HALTED cycle = 5.
- X on `opcode` outside OP_ADDR..STORE does not affect outputs.

## Structure
- `veririsc_pkg` holds:
  - `typedef enum logic [2:0] opcode_t` with the eight opcodes.
  - `typedef enum logic [3:0] state_t` with the nine states.
  - `function is_aluop(opcode_t)`.
- The same package is shared by the ALU and top level.
- No sub-module: one `always_ff` state register plus one `always_comb` decode; ~150 lines.
- Instantiated once in the VeriRISC top level, alongside two `register` instances (IR and AC).

## Test plan
- Reset: `rst`=1 for 2 cycles with opcode=X → all outputs 0. After release, cycle 1 is INST_ADDR with all 0, cycle 2 has mem_rd=1.
- LDA (opcode=5), zero=0 → mem_rd high in cycles 2–4 and 6–8; load_ir in cycles 3–4; inc_pc in cycle 5; load_ac in cycles 7–8; mem_wr never.
- STO (6) → mem_wr=1 only in cycle 8. SKZ (1) with zero=1 → inc_pc in cycles 5 and 7; with zero=0 → cycle 5 only.
- JMP (7) → load_pc=1 in cycles 7–8, inc_pc in cycle 5 only; the next instruction starts in cycle 9.
- HLT (0) → halt=1 from cycle 5 onward and held for ≥20 clocks with all other outputs 0. `rst` pulse → halt=0 and a normal fetch resumes.
- Reset mid-STORE during STO → mem_wr=0 in that cycle; next cycle is INST_ADDR.
